// File: rtl/score_display_arbiter.sv
// score_display_arbiter: owns the 8-digit BCD display word and shares it
// between the converted game score and two prioritised message requesters.
module score_display_arbiter #(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [26:0] score_in,
    input  logic        msg_a_valid_in,
    input  logic [31:0] msg_a_data_in,
    output logic        msg_a_ready_out,
    input  logic        msg_b_valid_in,
    input  logic [31:0] msg_b_data_in,
    output logic        msg_b_ready_out,
    output logic [31:0] val_out,
    output logic [1:0]  src_out,
    output logic        conv_busy_out
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
    localparam logic [26:0]   SCORE_MAX    = 27'd99_999_999;
    localparam logic [4:0]    ITER_LAST    = 5'd26;

    localparam logic [1:0] SRC_SCORE = 2'd0;
    localparam logic [1:0] SRC_A     = 2'd1;
    localparam logic [1:0] SRC_B     = 2'd2;

    typedef enum logic {
        IDLE,
        CONV
    } conv_state_t;

    conv_state_t state_q, state_d;

    logic [RW-1:0] refresh_q;
    logic          pending_q;
    logic [26:0]   bin_q;
    logic [31:0]   bcd_q;
    logic [4:0]    iter_q;
    logic [31:0]   score_bcd_q;

    logic          wrap;
    logic          start;
    logic          last_iter;
    logic [26:0]   score_sat;
    logic [31:0]   bcd_adj;
    logic [58:0]   shift_w;
    logic [31:0]   bcd_next;
    logic [26:0]   bin_next;

    logic          active_q;
    logic [1:0]    active_src_q;
    logic [31:0]   msg_q;
    logic [HW-1:0] hold_q;
    logic          accept_a;
    logic          accept_b;

    assign wrap      = (refresh_q == REFRESH_LAST);
    assign score_sat = (score_in > SCORE_MAX) ? SCORE_MAX : score_in;

    // Converter FSM: register the IDLE/CONV state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter FSM: start on a pending request, stop after 27 iterations
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = CONV;
                    start   = 1'b1;
                end
            end
            CONV: begin
                if (iter_q == ITER_LAST) begin
                    state_d   = IDLE;
                    last_iter = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh timer; a wrap raises a start request held until IDLE
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            refresh_q <= '0;
            pending_q <= 1'b1;
        end else begin
            refresh_q <= wrap ? '0 : refresh_q + RW'(1);
            if (wrap) begin
                pending_q <= 1'b1;
            end else if (start) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Double-dabble step: +3 on every digit >= 5, then shift {bcd, bin}
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_w  = {bcd_adj, bin_q} << 1;
        bcd_next = shift_w[58:27];
        bin_next = shift_w[26:0];
    end

    // Converter datapath; the score word only changes on a finished pass
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            score_bcd_q <= '0;
        end else if (start) begin
            bin_q  <= score_sat;
            bcd_q  <= '0;
            iter_q <= '0;
        end else if (state_q == CONV) begin
            bin_q  <= bin_next;
            bcd_q  <= bcd_next;
            iter_q <= iter_q + 5'd1;
            if (last_iter) begin
                score_bcd_q <= bcd_next;
            end
        end
    end

    assign conv_busy_out   = (state_q == CONV);
    assign msg_a_ready_out = !(active_q && (active_src_q == SRC_A));
    assign msg_b_ready_out = !active_q && !msg_a_valid_in;
    assign accept_a        = msg_a_valid_in && msg_a_ready_out;
    assign accept_b        = msg_b_valid_in && msg_b_ready_out;

    // Message owner: A may preempt B, hold counter retires the message
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active_q     <= 1'b0;
            active_src_q <= SRC_SCORE;
            msg_q        <= '0;
            hold_q       <= '0;
        end else if (accept_a) begin
            active_q     <= 1'b1;
            active_src_q <= SRC_A;
            msg_q        <= msg_a_data_in;
            hold_q       <= HOLD_LAST;
        end else if (accept_b) begin
            active_q     <= 1'b1;
            active_src_q <= SRC_B;
            msg_q        <= msg_b_data_in;
            hold_q       <= HOLD_LAST;
        end else if (active_q) begin
            if (hold_q == '0) begin
                active_q <= 1'b0;
            end else begin
                hold_q <= hold_q - HW'(1);
            end
        end
    end

    // Registered display mux feeding the driver
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            val_out <= '0;
            src_out <= SRC_SCORE;
        end else begin
            val_out <= active_q ? msg_q : score_bcd_q;
            src_out <= active_q ? active_src_q : SRC_SCORE;
        end
    end

endmodule

// File: tb/tb_score_display_arbiter.sv
// tb_score_display_arbiter: random and directed stimulus on two instances
// (short and long hold) checked against a timestamp-based reference model.
module tb_score_display_arbiter;

    localparam int R  = 64;
    localparam int H0 = 4;
    localparam int H1 = 100;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [26:0] score_in;
    logic        a_valid;
    logic [31:0] a_data;
    logic        b_valid;
    logic [31:0] b_data;

    logic        a_ready [2];
    logic        b_ready [2];
    logic [31:0] val     [2];
    logic [1:0]  src     [2];
    logic        busy    [2];

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int          k;
    logic [31:0] sbcd;
    logic [31:0] pend_val;
    int          pend_edge;
    bit          act     [2];
    int          msrc    [2];
    logic [31:0] mdata   [2];
    int          expire  [2];
    logic [31:0] exp_val [2];
    int          exp_src [2];

    always #5 clk_in = ~clk_in;

    score_display_arbiter #(
        .HOLD_CYCLES(H0),
        .REFRESH_CYCLES(R)
    ) u_dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .score_in(score_in),
        .msg_a_valid_in(a_valid),
        .msg_a_data_in(a_data),
        .msg_a_ready_out(a_ready[0]),
        .msg_b_valid_in(b_valid),
        .msg_b_data_in(b_data),
        .msg_b_ready_out(b_ready[0]),
        .val_out(val[0]),
        .src_out(src[0]),
        .conv_busy_out(busy[0])
    );

    score_display_arbiter #(
        .HOLD_CYCLES(H1),
        .REFRESH_CYCLES(R)
    ) u_dut_long (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .score_in(score_in),
        .msg_a_valid_in(a_valid),
        .msg_a_data_in(a_data),
        .msg_a_ready_out(a_ready[1]),
        .msg_b_valid_in(b_valid),
        .msg_b_data_in(b_data),
        .msg_b_ready_out(b_ready[1]),
        .val_out(val[1]),
        .src_out(src[1]),
        .conv_busy_out(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int unsigned v);
        int unsigned x;
        logic [31:0] r;
        x = (v > 99_999_999) ? 99_999_999 : v;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    task automatic model_reset();
        k         = 0;
        sbcd      = '0;
        pend_val  = '0;
        pend_edge = -1;
        for (int i = 0; i < 2; i++) begin
            act[i]     = 1'b0;
            msrc[i]    = 0;
            mdata[i]   = '0;
            expire[i]  = 0;
            exp_val[i] = '0;
            exp_src[i] = 0;
        end
    endtask

    // one clock edge of the reference behaviour, inputs as seen at the edge
    task automatic model_step();
        bit ra;
        bit rb;
        k++;
        for (int i = 0; i < 2; i++) begin
            exp_val[i] = act[i] ? mdata[i] : sbcd;
            exp_src[i] = act[i] ? msrc[i] : 0;
        end
        if ((k - 1) % R == 0) begin
            pend_val  = to_bcd(int'(score_in));
            pend_edge = k + 27;
        end
        if (k == pend_edge) sbcd = pend_val;
        for (int i = 0; i < 2; i++) begin
            ra = !(act[i] && msrc[i] == 1);
            rb = !act[i] && !a_valid;
            if (a_valid && ra) begin
                act[i]    = 1'b1;
                msrc[i]   = 1;
                mdata[i]  = a_data;
                expire[i] = k + hold_of(i);
            end else if (b_valid && rb) begin
                act[i]    = 1'b1;
                msrc[i]   = 2;
                mdata[i]  = b_data;
                expire[i] = k + hold_of(i);
            end else if (act[i] && k == expire[i]) begin
                act[i] = 1'b0;
            end
        end
    endtask

    function automatic bit model_busy();
        return (k >= 1) && (((k - 1) % R) < 27);
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("val%0d@%0d", i, k), val[i], exp_val[i]);
            check($sformatf("src%0d@%0d", i, k), 32'(src[i]), 32'(exp_src[i]));
            check($sformatf("busy%0d@%0d", i, k), 32'(busy[i]),
                  32'(model_busy()));
        end
    endtask

    // inputs were set just before: check readies, then take one edge
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("a_ready%0d@%0d", i, k), 32'(a_ready[i]),
                  32'(!(act[i] && msrc[i] == 1)));
            check($sformatf("b_ready%0d@%0d", i, k), 32'(b_ready[i]),
                  32'(!act[i] && !a_valid));
        end
        @(posedge clk_in);
        if (rst_n_in) model_step();
        #1;
        check_outputs();
    endtask

    task automatic wait_k(input int target);
        for (int n = 0; n < 400 && k < target; n++) tick();
        check("wait_k", 32'(k), 32'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int s;
        rst_n_in = 1'b0;
        score_in = 27'd12_345_678;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_data   = '0;
        b_data   = '0;
        model_reset();
        repeat (3) tick();
        #2 rst_n_in = 1'b1;

        // first conversion
        for (int j = 1; j <= 29; j++) begin
            tick();
            if (j <= 28) check("busy_first", 32'(busy[0]), 32'(j <= 27));
        end
        check("first_val", val[0], 32'h1234_5678);
        check("first_src", 32'(src[0]), 32'd0);

        // saturation boundaries
        score_in = 27'h7FF_FFFF;
        wait_k(93);
        check("sat_max", val[0], 32'h9999_9999);
        score_in = 27'd0;
        wait_k(157);
        check("sat_zero", val[0], 32'h0000_0000);
        score_in = 27'd99_999_999;
        wait_k(221);
        check("sat_edge", val[0], 32'h9999_9999);

        // message A hold
        a_valid = 1'b1;
        a_data  = 32'hABCD_0123;
        tick();
        a_valid = 1'b0;
        check("a_hold_ready", 32'(a_ready[0]), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("a_hold_val", val[0], 32'hABCD_0123);
            check("a_hold_src", 32'(src[0]), 32'd1);
            if (j < 3) check("a_hold_rdy", 32'(a_ready[0]), 32'd0);
        end
        tick();
        check("a_end_val", val[0], 32'h9999_9999);
        check("a_end_src", 32'(src[0]), 32'd0);

        // A and B together while idle
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 32'h1111_1111;
        b_data  = 32'h2222_2222;
        #1;
        check("both_b_ready", 32'(b_ready[0]), 32'd0);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("both_val", val[0], 32'h1111_1111);
        check("both_src", 32'(src[0]), 32'd1);
        repeat (4) tick();

        // B preempted by A, not resumed
        b_valid = 1'b1;
        b_data  = 32'h3333_3333;
        tick();
        b_valid = 1'b0;
        tick();
        check("pre_b_val", val[0], 32'h3333_3333);
        check("pre_b_src", 32'(src[0]), 32'd2);
        a_valid = 1'b1;
        a_data  = 32'h4444_4444;
        tick();
        a_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("pre_a_val", val[0], 32'h4444_4444);
            check("pre_a_src", 32'(src[0]), 32'd1);
        end
        tick();
        check("pre_end_val", val[0], 32'h9999_9999);
        check("pre_end_src", 32'(src[0]), 32'd0);

        // score refresh while a long B message is held
        for (int n = 0; n < 300 && act[1]; n++) tick();
        check("long_idle", 32'(act[1]), 32'd0);
        b_valid  = 1'b1;
        b_data   = 32'h5555_5555;
        score_in = 27'd42;
        tick();
        b_valid = 1'b0;
        t = k;
        wait_k(t + 100);
        check("bg_hold_val", val[1], 32'h5555_5555);
        check("bg_hold_src", 32'(src[1]), 32'd2);
        tick();
        check("bg_end_val", val[1], 32'h0000_0042);
        check("bg_end_src", 32'(src[1]), 32'd0);

        // asynchronous reset in the middle of a conversion
        score_in = 27'd87_654_321;
        s = ((k - 1) / R + 1) * R + 1;
        wait_k(s + 10);
        check("mid_busy", 32'(busy[0]), 32'd1);
        #2 rst_n_in = 1'b0;
        model_reset();
        #1;
        check("rst_val", val[0], 32'd0);
        check("rst_src", 32'(src[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_val_long", val[1], 32'd0);
        tick();
        tick();
        #2 rst_n_in = 1'b1;
        wait_k(28);
        check("rst_partial", val[0], 32'd0);
        tick();
        check("rst_conv", val[0], 32'h8765_4321);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            a_valid = ($urandom % 6) == 0;
            a_data  = $urandom;
            b_valid = ($urandom % 4) == 0;
            b_data  = $urandom;
            if (($urandom % 40) == 0) begin
                case ($urandom % 4)
                    0: score_in = 27'd0;
                    1: score_in = 27'd99_999_999;
                    2: score_in = 27'h7FF_FFFF;
                    default: score_in = 27'($urandom);
                endcase
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/score_display_arbiter.md
# score_display_arbiter

Owns the 32-bit BCD word that drives the 8-digit seven-segment display driver, and shares that display between three sources. The background source is the game score, given in binary. The block converts it to BCD with a sequential double-dabble engine on a periodic refresh. Two message requesters, A (high priority) and B (low priority), can take over the display for a fixed hold time through a valid/ready handshake. The block sits between the game logic and the display driver; its `val_out` connects directly to the driver's BCD input.

## Interface
- `HOLD_CYCLES`, 50_000_000: cycles a message stays on the display; must be ≥ 1.
- `REFRESH_CYCLES`, 1_000_000: score conversion start period; must be ≥ 32.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: one clock; reset is asynchronous and active-low.
- `score_in` input 27: binary score, sampled only at conversion start.
- `msg_a_valid_in` input 1: message A request.
- `msg_a_data_in` input 32: message A display word (opaque, 8 nibbles).
- `msg_a_ready_out` output 1: message A accepted when valid && ready at a clock edge.
- `msg_b_valid_in` input 1: message B request.
- `msg_b_data_in` input 32: message B display word.
- `msg_b_ready_out` output 1: message B handshake ready.
- `val_out` output 32: BCD/display word to the display driver (registered).
- `src_out` output 2: source of `val_out`: 0 = score, 1 = A, 2 = B (registered, aligned with `val_out`).
- `conv_busy_out` output 1: high while the converter is iterating.

## Operation
- **Converter states**
  - States are IDLE and CONV.
  - `start_pending` resets to 1, so the first conversion starts at the first edge after reset release.
  - Refresh counter runs 0..`REFRESH_CYCLES`-1 and wraps. At the wrap it sets `start_pending`.
  - IDLE && `start_pending` moves to CONV. At that edge the block latches `sat(score_in)`, clears the 32-bit BCD shift register, sets iteration count to 0 and clears `start_pending`.
  - `sat(x)` = min(x, 99_999_999).
- **CONV iteration** (one per cycle, 27 total)
  - Every nibble ≥ 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The iteration-27 edge writes the score BCD register and returns to IDLE.
  - `conv_busy_out` = (state == CONV).
- **Message arbitration**
  - State is `active` (0/1), `active_src` (A/B), a latched 32-bit word, and the hold counter.
  - `msg_a_ready_out` = !(active && active_src == A). This is combinational from registers only, with no valid→ready path.
  - `msg_b_ready_out` = !active && !`msg_a_valid_in`.
  - Accept A: latch data, `active` = 1, `active_src` = A, hold counter = `HOLD_CYCLES`-1. If B was active, B is preempted and dropped; it is not resumed.
  - Accept B: same, with `active_src` = B.
  - While active, the hold counter decrements each cycle. The edge where it reads 0 clears `active`.
  - A same-source re-request is not accepted in the clearing cycle; earliest acceptance is the following cycle.
- **Output mux** (registered each edge)
  - `val_out` = active ? latched message : score BCD.
  - `src_out` to match.
  - Score conversion continues unaffected while a message is shown.

## Timing
- **Reset values:** `val_out` = 0, `src_out` = 0, `conv_busy_out` = 0, `active` = 0 (so `msg_a_ready_out` = 1, and `msg_b_ready_out` = !`msg_a_valid_in`), score BCD = 0, refresh counter = 0, `start_pending` = 1.
- **Conversion latency:** start edge E0, iterations at E1..E27, `val_out` reflects the new score at E28 (if no message is active).
- **Start period:** one start per `REFRESH_CYCLES` cycles. Because `REFRESH_CYCLES` ≥ 32, a wrap never hits a busy converter. If it did, `start_pending` would hold until IDLE.
- **Message display window:** accept at edge T, `val_out`/`src_out` show the message from edge T+1, and revert to score at edge T+`HOLD_CYCLES`+1. That is exactly `HOLD_CYCLES` cycles.
- **Simultaneous A and B valid while idle:** A is accepted; B ready stays low.
- **Asynchronous reset mid-conversion or mid-hold:** all state returns to reset values immediately. A fresh conversion starts after release. A partial result is never shown.

## Test plan
- **Reset and first conversion** (`REFRESH_CYCLES` = 64, `HOLD_CYCLES` = 4): `score_in` = 12_345_678, release reset → `conv_busy_out` high for 27 cycles; `val_out` = 32'h1234_5678, `src_out` = 0 at 28 cycles after the first post-reset edge.
- **Saturation:** `score_in` = 134_217_727 → `val_out` = 32'h9999_9999. `score_in` = 0 → 32'h0000_0000. `score_in` = 99_999_999 → 32'h9999_9999.
- **Message hold:** A valid with data 32'hABCD_0123 for one cycle → `val_out` = 32'hABCD_0123, `src_out` = 1 for exactly 4 cycles, then score. `msg_a_ready_out` is low during the hold.
- **Priority and preemption:**
  - A and B both valid while idle → A is shown and B is not accepted.
  - B accepted, then A valid 2 cycles later → A shown for 4 cycles; after A clears, `val_out` returns to the score and B is not resumed.
- **Background refresh during message:** change `score_in` to 42 while B is held (`HOLD_CYCLES` raised to 100) → after B expires, `val_out` = 32'h0000_0042 with no extra delay.
- **Asynchronous reset mid-conversion:** assert `rst_n_in` low at iteration 10 → `val_out`, `src_out` and `conv_busy_out` go to 0 immediately. After release, a complete conversion gives the correct value at +28 cycles.
